// File: rtl/oka_pkg.sv
// rtl/oka_pkg.sv - shared constants, FSM states and operand split for the OKA sub-product front-end
package oka_pkg;

  localparam int OKA_N   = 32;
  localparam int OKA_H   = OKA_N / 2;
  localparam int OKA_PPW = 2 * OKA_H - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } oka_state_t;

  typedef struct packed {
    logic [OKA_H-1:0] even;
    logic [OKA_H-1:0] odd;
  } oka_split_t;

  // Even coefficients go to .even, odd coefficients to .odd (bit i = x^i of the half).
  function automatic oka_split_t oka_split(input logic [OKA_N-1:0] v);
    oka_split_t s;
    for (int i = 0; i < OKA_H; i++) begin
      s.even[i] = v[2*i];
      s.odd[i]  = v[2*i+1];
    end
    return s;
  endfunction

endpackage

// File: rtl/gf2_clmul_step.sv
// rtl/gf2_clmul_step.sv - one shift-and-XOR step of a carry-less multiply over BPC multiplier bits
module gf2_clmul_step #(
  parameter int H     = 16,
  parameter int BPC   = 1,
  parameter int OFF_W = 4
) (
  input  logic [2*H-2:0]   acc,
  input  logic [H-1:0]     mcand,
  input  logic [BPC-1:0]   mbits,
  input  logic [OFF_W-1:0] offset,
  output logic [2*H-2:0]   acc_next
);

  logic [2*H-2:0] wide;

  // Largest shift is H-1, so the shifted multiplicand always fits in 2H-1 bits.
  always_comb begin
    wide     = {{(H-1){1'b0}}, mcand};
    acc_next = acc;
    for (int k = 0; k < BPC; k++) begin
      if (mbits[k]) begin
        acc_next = acc_next ^ (wide << (int'(offset) + k));
      end
    end
  end

endmodule

// File: rtl/oka_subproduct_seq_32bit.sv
// rtl/oka_subproduct_seq_32bit.sv - sequential OKA 16x16 sub-product engine; OKA_SUBPRODUCT_BACK2BACK_EN enables accept-on-drain
module oka_subproduct_seq_32bit
  import oka_pkg::*;
#(
  parameter int N   = OKA_N,
  parameter int H   = N / 2,
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*H-2:0] pp1,
  output logic [2*H-2:0] pp2,
  output logic [2*H-2:0] pp3,
  output logic [2*H-2:0] pp4,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int STEPS = H / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int OFF_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  oka_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [H-1:0]     ae, ao, be, bo;
  logic             capture, step;
  logic [OFF_W-1:0] off;
  logic [2*H-2:0]   pp1_nxt, pp2_nxt, pp3_nxt, pp4_nxt;
  oka_split_t       a_s, b_s;

  assign a_s = oka_split(a_in);
  assign b_s = oka_split(b_in);
  assign off = OFF_W'(int'(cnt) * BPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    out_valid  = 1'b0;
`ifdef OKA_SUBPRODUCT_BACK2BACK_EN
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
`else
    in_ready   = (state == IDLE);
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture    = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
`ifdef OKA_SUBPRODUCT_BACK2BACK_EN
          // Drain and refill on the same edge.
          if (in_valid) begin
            capture    = 1'b1;
            state_next = CALC;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulators double as the registered outputs; they hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ae  <= '0;
      ao  <= '0;
      be  <= '0;
      bo  <= '0;
      pp1 <= '0;
      pp2 <= '0;
      pp3 <= '0;
      pp4 <= '0;
    end else if (capture) begin
      cnt <= '0;
      ae  <= a_s.even;
      ao  <= a_s.odd;
      be  <= b_s.even;
      bo  <= b_s.odd;
      pp1 <= '0;
      pp2 <= '0;
      pp3 <= '0;
      pp4 <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      pp1 <= pp1_nxt;
      pp2 <= pp2_nxt;
      pp3 <= pp3_nxt;
      pp4 <= pp4_nxt;
    end
  end

  gf2_clmul_step #(.H(H), .BPC(BPC), .OFF_W(OFF_W)) u_step1 (
    .acc(pp1), .mcand(ae), .mbits(be[off +: BPC]), .offset(off), .acc_next(pp1_nxt)
  );
  gf2_clmul_step #(.H(H), .BPC(BPC), .OFF_W(OFF_W)) u_step2 (
    .acc(pp2), .mcand(ae), .mbits(bo[off +: BPC]), .offset(off), .acc_next(pp2_nxt)
  );
  gf2_clmul_step #(.H(H), .BPC(BPC), .OFF_W(OFF_W)) u_step3 (
    .acc(pp3), .mcand(ao), .mbits(be[off +: BPC]), .offset(off), .acc_next(pp3_nxt)
  );
  gf2_clmul_step #(.H(H), .BPC(BPC), .OFF_W(OFF_W)) u_step4 (
    .acc(pp4), .mcand(ao), .mbits(bo[off +: BPC]), .offset(off), .acc_next(pp4_nxt)
  );

endmodule

// File: doc/oka_subproduct_seq_32bit.md
Name: oka_subproduct_seq_32bit

Overview:
- Sequential front-end of the 64-bit overlap-free Karatsuba (OKA) carry-less multiplier.
- Accepts two 32-bit GF(2) polynomials and splits each into even and odd coefficient halves.
- Computes the four 16x16 carry-less sub-products with shift-and-XOR accumulation, BPC multiplier bits per cycle.
- Presents the four 31-bit results, registered, to the downstream 32-bit overlap stage under a valid/ready handshake.

Parameters:
- N, 32, operand width; must be even.
- H, N/2, half-operand width (derived).
- BPC, 1, multiplier bits processed per cycle; must divide H (legal values 1, 2, 4, 8, 16).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a_in  input  N  operand A; bit i is the coefficient of x^i.
- b_in  input  N  operand B.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- pp1  output  2H-1  Ae*Be.
- pp2  output  2H-1  Ae*Bo.
- pp3  output  2H-1  Ao*Be.
- pp4  output  2H-1  Ao*Bo.
- out_valid  output  1  pp1..pp4 are final.
- out_ready  input  1  downstream accepts the results.

Behaviour:
- Split: Ae[i]=A[2i], Ao[i]=A[2i+1], for i=0..H-1. Same for B.
- All arithmetic is GF(2): XOR only, no carries. Each product is exactly 2H-1 bits, with no truncation.
- Reset (asynchronous, any state including mid-CALC): state=IDLE, counter=0, operand registers=0, pp1..pp4=0, out_valid=0, in_ready=1 once rst_n is released.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid, capture Ae/Ao/Be/Bo, clear accumulators, counter=0, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge, for k=0..BPC-1 with j=counter*BPC+k: each acc ^= (multiplier bit j) ? (multiplicand << j) : 0. Multiplier/multiplicand pairs are: pp1 Be/Ae, pp2 Bo/Ae, pp3 Be/Ao, pp4 Bo/Ao. Counter increments each edge. On the edge with counter==H/BPC-1, go to DONE.
  - DONE: out_valid=1, outputs stable. in_valid is ignored. On out_ready, go to IDLE; out_valid falls on that edge.
- Latency: out_valid is first high H/BPC edges after the accepting edge (16 for the default).
- Throughput without the optional feature: one result per H/BPC+2 cycles when out_ready is held high.
- pp1..pp4 hold their last value in IDLE until the next accept clears them.
- pp values are undefined to the consumer while out_valid=0.
- in_valid asserted in CALC or DONE: no effect. The requester must hold it until in_ready.
- out_ready asserted while out_valid=0: ignored.

Optional Feature:
- Macro OKA_SUBPRODUCT_BACK2BACK_EN.
- Defined: in_ready = IDLE | (DONE & out_ready). If in_valid is high on the output-handshake edge, the new operands are captured, accumulators are cleared and the FSM goes straight to CALC. Steady-state throughput is one result per H/BPC+1 cycles. in_ready is combinationally dependent on out_ready.
- Undefined: in_ready is a pure function of state, as described in Behaviour.

Decomposition:
- Package oka_pkg contains:
  - constants OKA_N=32, OKA_H=16, OKA_PPW=31;
  - state enum {IDLE, CALC, DONE};
  - a split function returning even/odd halves.
- Sub-module gf2_clmul_step (combinational): inputs acc, multiplicand, BPC multiplier bits and bit offset; output next acc. It is instantiated four times.

Test Plan:
- A=32'h1, B=32'h1 -> pp1=31'h1; pp2=pp3=pp4=0; out_valid 16 edges after accept (BPC=1).
- A=32'h2, B=32'h2 -> pp4=31'h1; pp1=pp2=pp3=0. The downstream overlap stage must give x^2, i.e. bit 2 set.
- A=B=32'hFFFF_FFFF -> pp1=pp2=pp3=pp4=31'h5555_5555.
- Backpressure: out_ready held low 10 cycles after out_valid -> pp outputs and out_valid stable, in_ready=0; a second in_valid in that window is not captured; results are released on out_ready.
- rst_n pulsed low at CALC cycle 7 -> all outputs 0 immediately, out_valid=0; the next operation from IDLE produces correct results.
- BPC=4 and, with OKA_SUBPRODUCT_BACK2BACK_EN, random operand streams vs. a software carry-less model -> latency 4 edges; back-to-back results every 5 cycles.
